// File: rtl/stage2_pkg.sv
// Shared definitions for the stage-2 FP16 datapath sequencer: stage count,
// stage encodings, tile-mode rule and sequencer FSM states.
package stage2_pkg;

  localparam int NUM_STAGES = 7;
  localparam int STG_W      = 3;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    STG_0        = 3'd0,
    STG_1        = 3'd1,
    STG_2        = 3'd2,
    STG_3        = 3'd3,
    STG_4        = 3'd4,
    STG_5        = 3'd5,
    STG_6        = 3'd6,
    STG_FINISHED = 3'd7
  } stage_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // The reconfigurable tile runs in mode 0 only while stage 1 is selected.
  function automatic logic stage_mode(input logic [2:0] stg);
    return (stg != 3'(STG_1));
  endfunction

endpackage

// File: rtl/stage_next_finder.sv
// Priority encoder: lowest stage with nonzero length at or above the current
// stage (incl_i=1) or strictly above it (incl_i=0); NUM_STAGES when none.
module stage_next_finder #(
  parameter int NUM_STAGES = 7,
  parameter int STG_W      = 3
) (
  input  logic [NUM_STAGES-1:0] mask_i,
  input  logic [STG_W-1:0]      cur_i,
  input  logic                  incl_i,
  output logic [STG_W-1:0]      next_o,
  output logic                  found_o
);

  logic [NUM_STAGES-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_cand
      assign cand[gi] = mask_i[gi] &
                        ((STG_W'(gi) > cur_i) | (incl_i & (STG_W'(gi) == cur_i)));
    end
  endgenerate

  always_comb begin
    next_o  = STG_W'(NUM_STAGES);
    found_o = |cand;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (cand[i]) next_o = STG_W'(i);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Handshaked stage/mode sequencer for the stage-2 FP16 datapath with per-stage
// beat budgets. Optional stall counter enabled by defining STAGE_SEQ_PERF_EN.
module stage_sequencer #(
  parameter int NUM_STAGES = stage2_pkg::NUM_STAGES,
  parameter int CNT_W      = stage2_pkg::CNT_W,
  parameter int STG_W      = stage2_pkg::STG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [STG_W-1:0] cfg_idx_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  output logic             cfg_err_o,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             out_ready_i,
  output logic             fire_o,
  output logic [STG_W-1:0] stage_o,
  output logic [CNT_W-1:0] beat_o,
  output logic             last_o,
  output logic             mode_o,
  output logic             busy_o,
  output logic             finished_o,
  output logic             done_o,
  output logic [15:0]      stall_cnt_o
);
  import stage2_pkg::*;

  seq_state_e       state_reg, state_next;
  logic [STG_W-1:0] stage_reg, stage_next;
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic             done_reg, done_next;
  logic             cfg_err_reg;
  logic [CNT_W-1:0] len_reg [NUM_STAGES];

  logic                  cfg_ok;
  logic                  start_go;
  logic [NUM_STAGES-1:0] mask_cur;
  logic [NUM_STAGES-1:0] mask_eff;
  logic [CNT_W-1:0]      cur_len;
  logic                  is_last;
  logic [STG_W-1:0]      start_stage, exit_stage;
  logic                  start_found, exit_found;

  assign cfg_ok   = cfg_we_i & (state_reg != RUN) & (cfg_idx_i < STG_W'(NUM_STAGES));
  assign start_go = start_i & (state_reg != RUN);

  // The start search sees a same-cycle config write as already committed.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_len
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          len_reg[gi] <= '0;
        end else if (cfg_ok && (cfg_idx_i == STG_W'(gi))) begin
          len_reg[gi] <= cfg_len_i;
        end
      end
      assign mask_cur[gi] = |len_reg[gi];
      assign mask_eff[gi] = (cfg_ok && (cfg_idx_i == STG_W'(gi))) ? (|cfg_len_i)
                                                                  : mask_cur[gi];
    end
  endgenerate

  stage_next_finder #(.NUM_STAGES(NUM_STAGES), .STG_W(STG_W)) u_start_finder (
    .mask_i  (mask_eff),
    .cur_i   ('0),
    .incl_i  (1'b1),
    .next_o  (start_stage),
    .found_o (start_found)
  );

  stage_next_finder #(.NUM_STAGES(NUM_STAGES), .STG_W(STG_W)) u_exit_finder (
    .mask_i  (mask_cur),
    .cur_i   (stage_reg),
    .incl_i  (1'b0),
    .next_o  (exit_stage),
    .found_o (exit_found)
  );

  always_comb begin
    cur_len = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_reg == STG_W'(i)) cur_len = len_reg[i];
    end
  end

  assign is_last    = (state_reg == RUN) & (beat_reg == cur_len - CNT_W'(1));
  assign in_ready_o = (state_reg == RUN) & out_ready_i;
  assign fire_o     = in_valid_i & in_ready_o;

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    beat_next  = beat_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          beat_next  = '0;
          stage_next = start_stage;
          if (start_found) begin
            state_next = RUN;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (fire_o) begin
          if (is_last) begin
            beat_next  = '0;
            stage_next = exit_stage;
            if (!exit_found) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        stage_next = '0;
        beat_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      stage_reg   <= '0;
      beat_reg    <= '0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stage_reg   <= stage_next;
      beat_reg    <= beat_next;
      done_reg    <= done_next;
      cfg_err_reg <= cfg_we_i & ~cfg_ok;
    end
  end

  assign stage_o    = stage_reg;
  assign beat_o     = beat_reg;
  assign last_o     = is_last;
  assign mode_o     = (stage_reg != STG_W'(STG_1));
  assign busy_o     = (state_reg == RUN);
  assign finished_o = (state_reg == DONE);
  assign done_o     = done_reg;
  assign cfg_err_o  = cfg_err_reg;

`ifdef STAGE_SEQ_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (start_go) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == RUN) && !fire_o && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: table-driven runs with a beat
// scoreboard, plus hand sequences for config errors, reset and saturation.
module tb_stage_sequencer;

`ifdef STAGE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_we_i;
  logic [2:0]  cfg_idx_i;
  logic [7:0]  cfg_len_i;
  logic        cfg_err_o;
  logic        start_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        out_ready_i;
  logic        fire_o;
  logic [2:0]  stage_o;
  logic [7:0]  beat_o;
  logic        last_o;
  logic        mode_o;
  logic        busy_o;
  logic        finished_o;
  logic        done_o;
  logic [15:0] stall_cnt_o;

  stage_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_len_i   (cfg_len_i),
    .cfg_err_o   (cfg_err_o),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_ready_i (out_ready_i),
    .fire_o      (fire_o),
    .stage_o     (stage_o),
    .beat_o      (beat_o),
    .last_o      (last_o),
    .mode_o      (mode_o),
    .busy_o      (busy_o),
    .finished_o  (finished_o),
    .done_o      (done_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0][7:0] lens;
    bit              toggle;
    int              rlo_start;
    int              rlo_len;
    int              wr_k;
    int              exp_done_k;
    int              exp_fires;
    int              exp_stalls;
  } vec_t;

  typedef struct packed {
    logic [2:0] stage;
    logic [7:0] beat;
    logic       last;
    logic       mode;
  } beat_t;

  vec_t       vecs [6];
  beat_t      sb [$];
  logic [7:0] m_len [7];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [6:0][7:0] mk_lens(input int a0, a1, a2, a3, a4, a5, a6);
    logic [6:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int len, input bit exp_err);
    cfg_we_i  = 1'b1;
    cfg_idx_i = 3'(idx);
    cfg_len_i = 8'(len);
    tick();
    cfg_we_i = 1'b0;
    check("cfg_err", int'(cfg_err_o), int'(exp_err));
    if (!exp_err) m_len[idx] = 8'(len);
  endtask

  // Expected beat order derived from the bench's own copy of the lengths.
  task automatic load_scoreboard();
    sb.delete();
    for (int s = 0; s < 7; s++) begin
      for (int b = 0; b < int'(m_len[s]); b++) begin
        sb.push_back('{stage: 3'(s), beat: 8'(b), last: (b == int'(m_len[s]) - 1),
                       mode: (s != 1)});
      end
    end
  endtask

  task automatic check_fire();
    beat_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_fire", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sb_stage", int'(stage_o), int'(e.stage));
      check("sb_beat",  int'(beat_o),  int'(e.beat));
      check("sb_last",  int'(last_o),  int'(e.last));
      check("sb_mode",  int'(mode_o),  int'(e.mode));
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int done_k;
    int fires;
    bit rdy;
    for (int s = 0; s < 7; s++) cfg_write(s, int'(v.lens[s]), 1'b0);
    load_scoreboard();
    start_i     = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    done_k  = 0;
    fires   = 0;
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      rdy         = !(k >= v.rlo_start && k < v.rlo_start + v.rlo_len);
      in_valid_i  = v.toggle ? (k % 2 == 0) : 1'b1;
      out_ready_i = rdy;
      cfg_we_i    = (k == v.wr_k);
      cfg_idx_i   = 3'd2;
      cfg_len_i   = 8'd9;
      @(negedge clk_i);
      if (k == 1 && v.exp_fires > 0) check("busy_at_t1", int'(busy_o), 1);
      if (!rdy) begin
        check("stall_no_fire", int'(fire_o), 0);
        check("stall_ready_low", int'(in_ready_o), 0);
      end
      if (v.wr_k != 0 && k == v.wr_k + 1) check("cfg_err_in_run", int'(cfg_err_o), 1);
      if (fire_o) begin
        fires++;
        check_fire();
      end
      if (done_o) done_k = k;
      tick();
    end
    cfg_we_i = 1'b0;
    check("done_cycle", done_k, v.exp_done_k);
    check("fire_count", fires, v.exp_fires);
    check("sb_empty", sb.size(), 0);
    check("finished", int'(finished_o), 1);
    check("stage_done", int'(stage_o), 7);
    check("done_pulse_end", int'(done_o), 0);
    check("busy_done", int'(busy_o), 0);
    check("stall_cnt", int'(stall_cnt_o), PERF ? v.exp_stalls : 0);
    $display("[TB] vec %0d: done at cycle %0d, %0d beats", id, done_k, fires);
  endtask

  initial begin
    int n_sat;
    int fires;
    int done_k;
    bit hit;

    vecs[0] = '{mk_lens(2,3,0,1,0,0,1), 1'b0, 0, 0, 0,  8, 7, 0};
    vecs[1] = '{mk_lens(2,3,0,1,0,0,1), 1'b1, 0, 0, 0, 15, 7, 7};
    vecs[2] = '{mk_lens(0,0,0,0,0,0,0), 1'b0, 0, 0, 0,  1, 0, 0};
    vecs[3] = '{mk_lens(2,3,0,1,0,0,1), 1'b0, 2, 5, 2, 13, 7, 5};
    vecs[4] = '{mk_lens(0,0,0,0,0,0,5), 1'b0, 0, 0, 0,  6, 5, 0};
    vecs[5] = '{mk_lens(1,1,1,1,1,1,1), 1'b1, 0, 0, 0, 15, 7, 7};

    for (int s = 0; s < 7; s++) m_len[s] = 8'd0;
    rst_i       = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_idx_i   = 3'd0;
    cfg_len_i   = 8'd0;
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    tick();
    tick();
    check("rst_stage", int'(stage_o), 0);
    check("rst_beat", int'(beat_o), 0);
    check("rst_mode", int'(mode_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_finished", int'(finished_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_stall", int'(stall_cnt_o), 0);
    rst_i = 1'b0;
    tick();

    // Out-of-range index in IDLE: rejected for exactly one cycle.
    cfg_write(7, 5, 1'b1);
    tick();
    check("cfg_err_one_cycle", int'(cfg_err_o), 0);
    $display("[TB] cfg idx=7 write in IDLE rejected");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Stall counter: start clears it, long back-pressure saturates it, DONE holds it.
    n_sat = PERF ? 65540 : 20;
    start_i     = 1'b1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("stall_clear_on_start", int'(stall_cnt_o), 0);
    for (int k = 0; k < n_sat; k++) tick();
    check("stall_saturate", int'(stall_cnt_o), PERF ? 65535 : 0);
    out_ready_i = 1'b1;
    fires  = 0;
    done_k = 0;
    for (int k = 1; k <= 50 && done_k == 0; k++) begin
      @(negedge clk_i);
      if (fire_o) fires++;
      if (done_o) done_k = k;
      tick();
    end
    check("sat_fires", fires, 7);
    check("sat_done_seen", int'(done_k != 0), 1);
    tick();
    check("stall_hold_done", int'(stall_cnt_o), PERF ? 65535 : 0);
    $display("[TB] saturation run: stall_cnt=%0d", stall_cnt_o);

    // Asynchronous reset at beat 1 of stage 1 aborts the run and clears lengths.
    for (int s = 0; s < 7; s++) cfg_write(s, int'(vecs[0].lens[s]), 1'b0);
    load_scoreboard();
    start_i     = 1'b1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    hit = 1'b0;
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(negedge clk_i);
      if (fire_o) check_fire();
      if (stage_o == 3'd1 && beat_o == 8'd1) hit = 1'b1;
      else tick();
    end
    check("reached_s1_b1", int'(hit), 1);
    rst_i = 1'b1;
    #1;
    check("arst_stage", int'(stage_o), 0);
    check("arst_beat", int'(beat_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_ready", int'(in_ready_o), 0);
    check("arst_mode", int'(mode_o), 1);
    tick();
    rst_i = 1'b0;
    for (int s = 0; s < 7; s++) m_len[s] = 8'd0;
    sb.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("post_rst_finished", int'(finished_o), 1);
    check("post_rst_done", int'(done_o), 1);
    check("post_rst_stage", int'(stage_o), 7);
    $display("[TB] reset mid-run: lengths cleared, empty run finished");

    // Config write and start in the same cycle: start sees the new length.
    cfg_we_i  = 1'b1;
    cfg_idx_i = 3'd4;
    cfg_len_i = 8'd2;
    start_i   = 1'b1;
    tick();
    cfg_we_i = 1'b0;
    start_i  = 1'b0;
    m_len[4] = 8'd2;
    load_scoreboard();
    check("wr_start_busy", int'(busy_o), 1);
    check("wr_start_stage", int'(stage_o), 4);
    check("wr_start_err", int'(cfg_err_o), 0);
    fires  = 0;
    done_k = 0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      @(negedge clk_i);
      if (fire_o) begin
        fires++;
        check_fire();
      end
      if (done_o) done_k = k;
      tick();
    end
    check("wr_start_fires", fires, 2);
    check("wr_start_done", done_k, 3);
    $display("[TB] cfg+start same cycle: %0d beats in stage 4", fires);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Handshaked sequencer that drives the `stage`/`mode` selects of the stage-2 FP16 datapath (div/mul/sqrt/cmp lanes). It replaces the free-running step counter and cumulative boundary comparison with per-stage beat budgets. Stages advance only on accepted beats, so upstream bubbles or downstream back-pressure never skew which stage a beat is processed in. It sits between the operand fetch stream and the datapath, and reports completion to the top-level controller.

## Interface
Parameters:
- NUM_STAGES, 7, number of active stages (0..NUM_STAGES-1); encoding NUM_STAGES means finished
- CNT_W, 8, width of per-stage beat length and beat index
- STG_W, 3, width of stage encoding; must satisfy 2**STG_W > NUM_STAGES

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_we_i  in  1  write stage length
- cfg_idx_i  in  STG_W  stage index to write
- cfg_len_i  in  CNT_W  beats in that stage; 0 = skip stage
- cfg_err_o  out  1  one-cycle pulse: write rejected (busy, or idx >= NUM_STAGES)
- start_i  in  1  begin a run
- in_valid_i  in  1  upstream beat available
- in_ready_o  out  1  sequencer accepts beat
- out_ready_i  in  1  downstream can take datapath result
- fire_o  out  1  in_valid_i & in_ready_o; datapath result valid this cycle
- stage_o  out  STG_W  current stage select to datapath
- beat_o  out  CNT_W  beat index within stage
- last_o  out  1  current beat is last of its stage
- mode_o  out  1  reconfig tile mode: 0 when stage_o==1, else 1
- busy_o  out  1  state==RUN
- finished_o  out  1  state==DONE
- done_o  out  1  one-cycle pulse on entry to DONE
- stall_cnt_o  out  16  stall counter (see Configuration)

## Operation
- Config regs len[0..NUM_STAGES-1], reset 0, written only in IDLE or DONE; a write in RUN or with an out-of-range idx is dropped and pulses cfg_err_o.
- FSM states:
  - IDLE: stage_o=0, beat_o=0, in_ready_o=0.
  - start_i: go to RUN at the first stage s with len[s]!=0. If all lengths are 0, go straight to DONE.
- RUN: in_ready_o = out_ready_i. On fire_o:
  - If beat_o == len[stage_o]-1, jump to the next higher stage with nonzero length and set beat_o=0; if there is none, go to DONE.
  - Otherwise increment beat_o.
- DONE: stage_o=NUM_STAGES (7), finished_o=1, in_ready_o=0. Holds until start_i, which restarts as from IDLE.
- start_i in RUN is ignored.
- last_o = (state==RUN) & (beat_o == len[stage_o]-1).
- Beat index never wraps: it is bounded by len-1 and len <= 2**CNT_W-1.
- Reset values: IDLE, stage_o=0, beat_o=0, all flags 0, mode_o=1, stall_cnt_o=0.
- Reset mid-run aborts immediately to IDLE. Config registers clear to 0.

## Timing
- start_i sampled at cycle t → busy_o and in_ready_o are available at t+1.
- fire_o is combinational from in_valid_i and out_ready_i. stage_o/beat_o are registered and change the cycle after fire_o.
- Final fire at cycle t → finished_o=1 from t+1, done_o high only at t+1.
- All-zero run: start at t → DONE and done_o at t+1.
- A cfg write and start_i in the same cycle: the write commits first, and the start uses the updated lengths.

## Configuration
- STAGE_SEQ_PERF_EN defined: stall_cnt_o counts RUN cycles without fire_o. It saturates at 0xFFFF, clears on start_i, and holds its value in DONE.
- STAGE_SEQ_PERF_EN undefined: the counter logic is absent and stall_cnt_o is tied to 0.

## Structure
- Shared package stage2_pkg:
  - NUM_STAGES and STG_W constants.
  - Stage encoding enum including STG_FINISHED=7 and the mode rule (stage 1 → mode 0).
  - FSM state typedef {IDLE, RUN, DONE}.
- Sub-module stage_next_finder: combinational priority encoder. Input is the nonzero-length mask plus the current stage; outputs are the next stage and a found flag. It is used both at start and on stage exit.

## Test plan
- len={2,3,0,1,0,0,1}, in_valid and out_ready held high, start → stage sequence 0,0,1,1,1,3,6, then 7. done_o asserted 8 cycles after start, mode_o=0 only during the three stage-1 beats.
- Same config, in_valid toggled every other cycle → identical stage/beat sequence over 14 cycles; with STAGE_SEQ_PERF_EN, stall_cnt_o=7 at DONE.
- All len=0, start → finished_o and done_o at t+1, zero fires.
- cfg write idx=2 during RUN, and idx=7 in IDLE → cfg_err_o pulses both times, len unchanged.
- Reset asserted at beat 1 of stage 1 → immediate IDLE, stage_o=0, all len=0; a subsequent start goes to DONE in one cycle.
- out_ready_i low for 5 cycles mid-stage → no fire, beat_o frozen, stall_cnt_o += 5; saturation check after forcing 0xFFFF stall cycles.
